cva5_fifo_flushable: RTL and testbench
======================================

Name: cva5_fifo_flushable

Overview:
Parametrised successor to the small lq-entry FIFO. It generalises storage to any depth (non-power-of-two allowed) and any data width. It adds a synchronous flush, an exact occupancy count, an almost-full threshold and sticky overflow/underflow error flags. It is used as the generic buffering FIFO for load/store queue entries and writeback staging, where pipeline flushes must discard in-flight entries.

Parameters:
WIDTH, 32, data word width in bits.
DEPTH, 5, number of entries; any value >= 1.
ALMOST_FULL_THRESH, DEPTH-1, almost_full asserts when count >= this value; legal range 1..DEPTH.
CW, $clog2(DEPTH+1), derived width of the count output; not overridable.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous discard of all entries.
push  input  1  enqueue data_in this cycle.
data_in  input  WIDTH  enqueue data.
pop  input  1  dequeue the head entry this cycle.
data_out  output  WIDTH  head entry; valid only when valid=1.
valid  output  1  FIFO is non-empty (count != 0).
full  output  1  count == DEPTH.
almost_full  output  1  count >= ALMOST_FULL_THRESH.
count  output  CW  current occupancy, 0..DEPTH.
overflow_err  output  1  sticky: a push was dropped.
underflow_err  output  1  sticky: a pop was ignored.

Behaviour:
- Reset (async, rst=1): read_ptr=0, write_ptr=0, count=0, overflow_err=0, underflow_err=0. Consequently valid=0, full=0, almost_full=0. data_out is X/don't-care. Storage array is not reset.
- Pointers: binary, range 0..DEPTH-1. Increment wraps DEPTH-1 -> 0 explicitly; power-of-two wrap must not be relied on.
- Effective push: push_ok = push & (~full | pop_ok).
- Effective pop: pop_ok = pop & valid.
- Write: on push_ok, storage[write_ptr] <= data_in and write_ptr advances.
- Read: on pop_ok, read_ptr advances.
- Count: count_next = count + push_ok - pop_ok, computed at CW bits. Never exceeds DEPTH and never goes below 0.
- Latency: data pushed into an empty FIFO appears on data_out with valid=1 the next cycle. data_out = storage[read_ptr], combinational read.
- Simultaneous push and pop:
  - When full: both succeed and count stays DEPTH.
  - When empty: the pop is ignored and flags underflow; the push succeeds (see Optional Feature for the exception).
- Overflow: push & full & ~pop drops data_in, leaves pointers and count unchanged, and sets overflow_err=1 next cycle.
- Underflow: pop & ~valid sets underflow_err=1 next cycle and changes no other state.
- Error flags: both are sticky until rst; flush does not clear them.
- Flush: highest priority. Next cycle read_ptr=write_ptr=0 and count=0. Any push/pop in the same cycle is discarded and does not set error flags.
- Reset mid-operation: asynchronous clear regardless of push/pop/flush. The first push after rst deasserts behaves as if into an empty FIFO.
- DEPTH=1: a single register plus a valid bit. The same rules apply, including push&pop when full (replace).
- Assertions (simulation only): ALMOST_FULL_THRESH in 1..DEPTH; count <= DEPTH at all times.

Optional Feature:
FIFO_FALLTHROUGH_EN.
- Defined: when count==0 and push=1, data_out=data_in and valid=1 combinationally in the same cycle.
  - If pop=1 in that cycle, the word is consumed directly. No write occurs, pointers and count are unchanged, and underflow_err is not set.
  - If pop=0, the word is written normally.
- Undefined: valid is purely registered (count!=0). A push into an empty FIFO is visible only the next cycle, and pop with count==0 is an underflow as above.

Test Plan:
- Fill and drain: DEPTH=5, THRESH=4; push 0xA0..0xA4 on consecutive cycles. Required: count 1,2,3,4,5; almost_full at count=4; full at 5. Then pop x5: data_out reads 0xA0..0xA4 in order, then valid=0 and count=0.
- Wrap-around on non-power-of-two depth: 12 interleaved push/pop pairs at steady occupancy 3. Required: output order matches input order and the pointers wrap 4->0 without a skipped slot.
- Full with simultaneous push and pop: at count=5, push 0xB5 and pop together. Required: 0xA0 is dequeued, count stays 5, and 0xB5 is eventually read last. Next, push alone at full: count stays 5, overflow_err=1 and remains 1 after a following flush.
- Underflow: pop with count=0 and push=0. Required: underflow_err=1 next cycle; count, valid and pointers are unchanged.
- Flush priority: at count=3, assert flush+push+pop in one cycle. Required: count=0 next cycle, valid=0, no error flag set. A subsequent push of 0xC0 then reads out 0xC0.
- Async reset mid-stream: assert rst between clock edges at count=4. Required: count=0, valid=0 and error flags cleared immediately, without waiting for a clock edge. With FIFO_FALLTHROUGH_EN, a push+pop of 0xD0 at empty gives data_out=0xD0, valid=1 that cycle, count=0 after, and underflow_err=0.

Source files
------------

// File: rtl/cva5_fifo_flushable.sv
// Flushable FIFO of any depth/width with occupancy count, almost-full and sticky error flags.
// Optional FIFO_FALLTHROUGH_EN: push into an empty FIFO is visible on data_out in the same cycle.
module cva5_fifo_flushable #(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned DEPTH              = 5,
    parameter int unsigned ALMOST_FULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         pop,
    output logic [WIDTH-1:0]             data_out,
    output logic                         valid,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err,
    output logic                         underflow_err
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    read_ptr;
    logic [PW-1:0]    write_ptr;
    logic             nonempty;
    logic             bypass_c;
    logic             push_ok_c;
    logic             pop_ok_c;
    logic [CW-1:0]    count_next_c;

    // Explicit wrap so non-power-of-two depths never skip or alias a slot
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Qualified push/pop and next occupancy
    always_comb begin
        bypass_c = 1'b0;
`ifdef FIFO_FALLTHROUGH_EN
        bypass_c = ~nonempty & push & pop;
`endif
        pop_ok_c     = pop & nonempty;
        push_ok_c    = push & (~full | pop_ok_c) & ~bypass_c;
        count_next_c = count + CW'(push_ok_c) - CW'(pop_ok_c);
    end

    // Control state; flush outranks push/pop but leaves the sticky error flags alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_ptr      <= '0;
            write_ptr     <= '0;
            count         <= '0;
            nonempty      <= 1'b0;
            full          <= 1'b0;
            almost_full   <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            read_ptr    <= '0;
            write_ptr   <= '0;
            count       <= '0;
            nonempty    <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (push_ok_c)
                write_ptr <= ptr_inc(write_ptr);
            if (pop_ok_c)
                read_ptr <= ptr_inc(read_ptr);
            count       <= count_next_c;
            nonempty    <= (count_next_c != '0);
            full        <= (count_next_c == CW'(DEPTH));
            almost_full <= (count_next_c >= CW'(ALMOST_FULL_THRESH));
            if (push & ~push_ok_c & ~bypass_c)
                overflow_err <= 1'b1;
            if (pop & ~pop_ok_c & ~bypass_c)
                underflow_err <= 1'b1;
        end
    end

    // Data storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push_ok_c & ~flush)
            storage[write_ptr] <= data_in;
    end

`ifdef FIFO_FALLTHROUGH_EN
    assign data_out = nonempty ? storage[read_ptr] : data_in;
    assign valid    = nonempty | push;
`else
    assign data_out = storage[read_ptr];
    assign valid    = nonempty;
`endif

    a_thresh_legal: assert property (@(posedge clk)
        (ALMOST_FULL_THRESH >= 1) && (ALMOST_FULL_THRESH <= DEPTH));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_cva5_fifo_flushable.sv
// Self-checking bench for cva5_fifo_flushable: directed scenarios plus random traffic vs a queue model.
module tb_cva5_fifo_flushable;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 5;
    localparam int unsigned THRESH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             valid, full, almost_full, overflow_err, underflow_err;
    logic [2:0]       count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q[$];
    bit               m_of = 0;
    bit               m_uf = 0;

    cva5_fifo_flushable #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid(valid), .full(full), .almost_full(almost_full),
        .count(count), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all observable state against the model (inputs idle)
    task automatic check_state(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".valid"}, 32'(valid), 32'(n != 0));
        check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= THRESH));
        check({tag, ".overflow_err"}, 32'(overflow_err), 32'(m_of));
        check({tag, ".underflow_err"}, 32'(underflow_err), 32'(m_uf));
        if (n != 0)
            check({tag, ".data_out"}, data_out, q[0]);
    endtask

    task automatic model_step(input bit f, input bit pu, input bit po, input logic [WIDTH-1:0] d);
        int  n;
        bit  do_pop, do_push, ft;
        n  = q.size();
        ft = 0;
`ifdef FIFO_FALLTHROUGH_EN
        ft = 1;
`endif
        if (f) begin
            q.delete();
        end else if (ft && n == 0 && pu && po) begin
            // word passes straight through; nothing stored
        end else begin
            do_pop  = po && (n > 0);
            do_push = pu && ((n < DEPTH) || do_pop);
            if (po && !do_pop)  m_uf = 1;
            if (pu && !do_push) m_of = 1;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
    endtask

    task automatic cycle(input string tag, input bit f, input bit pu, input bit po,
                         input logic [WIDTH-1:0] d);
        @(negedge clk);
        check_state(tag);
        flush = f; push = pu; pop = po; data_in = d;
`ifdef FIFO_FALLTHROUGH_EN
        #1;
        if (!f && pu && q.size() == 0) begin
            check({tag, ".ft_valid"}, 32'(valid), 32'd1);
            check({tag, ".ft_data"}, data_out, d);
        end
`endif
        @(posedge clk);
        model_step(f, pu, po, d);
        #1;
        flush = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset.count", 32'(count), 32'd0);
        check("reset.valid", 32'(valid), 32'd0);
        check("reset.full", 32'(full), 32'd0);
        check("reset.almost_full", 32'(almost_full), 32'd0);
        check("reset.errs", 32'({overflow_err, underflow_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) cycle("fill", 0, 1, 0, 32'hA0 + 32'(i));
        for (int i = 0; i < 5; i++) cycle("drain", 0, 0, 1, 32'h0);
        cycle("underflow", 0, 0, 1, 32'h0);
        cycle("underflow_post", 0, 0, 0, 32'h0);
        check("underflow.sticky", 32'(underflow_err), 32'd1);

        for (int i = 0; i < 3; i++) cycle("wrap_pre", 0, 1, 0, 32'h10 + 32'(i));
        for (int i = 0; i < 12; i++) cycle("wrap", 0, 1, 1, 32'h20 + 32'(i));
        for (int i = 0; i < 3; i++) cycle("wrap_drain", 0, 0, 1, 32'h0);

        for (int i = 0; i < 5; i++) cycle("refill", 0, 1, 0, 32'hA0 + 32'(i));
        cycle("full_pushpop", 0, 1, 1, 32'hB5);
        cycle("overflow", 0, 1, 0, 32'hEE);
        cycle("flush_after_of", 1, 0, 0, 32'h0);
        cycle("of_sticky", 0, 0, 0, 32'h0);
        check("overflow.sticky", 32'(overflow_err), 32'd1);

        for (int i = 0; i < 3; i++) cycle("fp_pre", 0, 1, 0, 32'h30 + 32'(i));
        cycle("flush_prio", 1, 1, 1, 32'h99);
        cycle("post_flush_push", 0, 1, 0, 32'hC0);
        cycle("post_flush_pop", 0, 0, 1, 32'h0);

        // Asynchronous reset between clock edges at count=4
        for (int i = 0; i < 4; i++) cycle("rst_pre", 0, 1, 0, 32'h40 + 32'(i));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst.count", 32'(count), 32'd0);
        check("async_rst.valid", 32'(valid), 32'd0);
        check("async_rst.errs", 32'({overflow_err, underflow_err}), 32'd0);
        q.delete(); m_of = 0; m_uf = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle("ft_pushpop", 0, 1, 1, 32'hD0);
        cycle("after_rst_push", 0, 1, 0, 32'hD1);
        cycle("after_rst_pop", 0, 0, 1, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            n = q.size();
            cycle("rand", ($urandom % 25) == 0, ($urandom % 10) < 6, ($urandom % 10) < 5, $urandom);
        end
        @(negedge clk);
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
